// File: rtl/iomem_timer_if.sv
// iomem bus bundle between the CPU (master) and a peripheral responder (slave).
// The SoC ORs rdata/ready from all responders, so a slave drives zeros when idle.
interface iomem_timer_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

// File: rtl/iomem_timer.sv
// Prescaled down-counting timer on the iomem bus: one-shot or auto-reload,
// sticky EXPIRED flag and a registered level interrupt.
module iomem_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic          clk_i,
   input  logic          reset_i,
   iomem_timer_if.slave  bus,
   output logic          irq_o
);

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;

   localparam logic [5:0] OFF_CTRL     = 6'h00;
   localparam logic [5:0] OFF_PRESCALE = 6'h01;
   localparam logic [5:0] OFF_RELOAD   = 6'h02;
   localparam logic [5:0] OFF_COUNT    = 6'h03;
   localparam logic [5:0] OFF_STATUS   = 6'h04;

   localparam logic [PRESCALE_W-1:0] PC_ONE = 1;

   logic                  ready_q,    ready_d;
   logic [31:0]           rdata_q,    rdata_d;
   ctrl_t                 ctrl_q,     ctrl_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [31:0]           reload_q,   reload_d;
   logic [31:0]           count_q,    count_d;
   logic                  expired_q,  expired_d;
   logic [PRESCALE_W-1:0] pc_q,       pc_d;
   logic                  irq_q,      irq_d;

   logic        hit;
   logic        sel;
   logic        wr;
   logic [5:0]  offset;
   logic        tick;
   logic [31:0] rd_val;
   logic [31:0] merged;
   logic        expire_set;
   logic        expire_clr;
   logic        addr_lsb_unused;

   // Per-byte merge of bus data onto the current register image.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   assign addr_lsb_unused = ^bus.iomem_addr[1:0];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      hit        = (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
      sel        = bus.iomem_valid && hit && !ready_q;
      wr         = sel && (bus.iomem_wstrb != 4'b0000);
      offset     = bus.iomem_addr[7:2];
      tick       = ctrl_q.en && (pc_q == prescale_q);
      expire_set = 1'b0;
      expire_clr = 1'b0;

      unique case (offset)
         OFF_CTRL:     rd_val = {29'd0, ctrl_q};
         OFF_PRESCALE: rd_val = 32'(prescale_q);
         OFF_RELOAD:   rd_val = reload_q;
         OFF_COUNT:    rd_val = count_q;
         OFF_STATUS:   rd_val = {31'd0, expired_q};
         default:      rd_val = 32'd0;
      endcase
      merged = apply_wstrb(rd_val, bus.iomem_wdata, bus.iomem_wstrb);

      ready_d    = sel;
      rdata_d    = sel ? rd_val : 32'd0;
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      reload_d   = reload_q;
      count_d    = count_q;

      if (!ctrl_q.en)  pc_d = '0;
      else if (tick)   pc_d = '0;
      else             pc_d = pc_q + PC_ONE;

      if (tick) begin
         if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
         end else begin
            expire_set = 1'b1;
            if (ctrl_q.auto_reload) count_d   = reload_q;
            else                    ctrl_d.en = 1'b0;
         end
      end

      // Bus writes come last so they override same-cycle timer updates.
      if (wr) begin
         unique case (offset)
            OFF_CTRL: begin
               ctrl_d = ctrl_t'(merged[2:0]);
               if (!ctrl_q.en && merged[0]) pc_d = '0;
            end
            OFF_PRESCALE: begin
               prescale_d = merged[PRESCALE_W-1:0];
               pc_d       = '0;
            end
            OFF_RELOAD:   reload_d   = merged;
            OFF_COUNT:    count_d    = merged;
            OFF_STATUS:   expire_clr = bus.iomem_wstrb[0] && bus.iomem_wdata[0];
            default:      ;
         endcase
      end

      // A new expiry beats a same-cycle write-1-to-clear.
      expired_d = expire_set ? 1'b1 : (expire_clr ? 1'b0 : expired_q);
      irq_d     = expired_q && ctrl_q.irq_en;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
      if (reset_i) begin
         ready_q    <= 1'b0;
         rdata_q    <= 32'd0;
         ctrl_q     <= '0;
         prescale_q <= '0;
         reload_q   <= 32'd0;
         count_q    <= 32'd0;
         expired_q  <= 1'b0;
         pc_q       <= '0;
         irq_q      <= 1'b0;
      end else begin
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         pc_q       <= pc_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign irq_o           = irq_q;

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: directed bus/collision cases plus random
// timer configurations checked against a time-based model of the timer.
module tb_iomem_timer;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic clk;
   logic reset;
   logic irq;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   int   fails = 0;

   iomem_timer_if bus ();

   iomem_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus),
      .irq_o   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Timer model: enable edge, prescale, start count, reload, mode, last clear edge.
   int m_e, m_p, m_c, m_r, m_clr;
   bit m_auto, m_irqen;

   function automatic int ticks_by(int t);
      int n;
      if (t <= m_e) return 0;
      n = (t - m_e) / (m_p + 1);
      if (!m_auto && n > m_c + 1) n = m_c + 1;
      return n;
   endfunction

   function automatic bit expiry_tick(int k);
      if (k < m_c + 1) return 1'b0;
      if (!m_auto) return k == m_c + 1;
      return ((k - m_c - 1) % (m_r + 1)) == 0;
   endfunction

   function automatic int count_after(int t);
      int n;
      n = ticks_by(t);
      if (n <= m_c) return m_c - n;
      if (!m_auto) return 0;
      return m_r - ((n - m_c - 1) % (m_r + 1));
   endfunction

   function automatic bit expired_after(int t);
      for (int k = 1; k <= ticks_by(t); k++) begin
         if (expiry_tick(k) && (m_e + k * (m_p + 1)) >= m_clr) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int ctrl_after(int t);
      bit en;
      en = m_auto ? 1'b1 : (ticks_by(t) < m_c + 1);
      return {m_irqen, m_auto, en};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int commit);
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = addr;
      bus.iomem_wstrb = strb;
      bus.iomem_wdata = wdata;
      check("ready_before_edge", bus.iomem_ready, 0);
      @(posedge clk);
      #1;
      commit = cyc;
      check("ready_pulse", bus.iomem_ready, 1);
      rdata = bus.iomem_rdata;
      @(negedge clk);
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      @(posedge clk);
      #1;
      check("ready_drop", bus.iomem_ready, 0);
      check("rdata_idle", bus.iomem_rdata, 0);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data, output int commit);
      logic [31:0] dummy;
      bus_xfer(BASE + 32'(off), 4'b1111, data, dummy, commit);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] data, output int commit);
      bus_xfer(BASE + 32'(off), 4'b0000, 32'd0, data, commit);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic start_timer(input int p, input int c, input int r, input bit au, input bit ie);
      int t;
      reset_dut();
      m_p = p; m_c = c; m_r = r; m_auto = au; m_irqen = ie; m_clr = 0;
      wr(8'h08, 32'(r), t);
      wr(8'h04, 32'(p), t);
      wr(8'h0C, 32'(c), t);
      wr(8'h00, {29'd0, ie, au, 1'b1}, t);
      m_e = t;
   endtask

   task automatic wait_commit_at(input int edge_no);
      while (cyc < edge_no - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic poll_irq(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         #1;
         check(tag, irq, {31'd0, m_irqen && expired_after(cyc - 1)});
      end
   endtask

   initial begin
      logic [31:0] d;
      int          t;

      reset = 1'b1;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      bus.iomem_addr  = 32'd0;
      bus.iomem_wdata = 32'd0;
      m_e = 0; m_p = 0; m_c = 0; m_r = 0; m_clr = 0; m_auto = 0; m_irqen = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", bus.iomem_ready, 0);
      check("reset_rdata", bus.iomem_rdata, 0);
      check("reset_irq", irq, 0);
      reset_dut();

      // Every register reads 0 after reset; unmapped offset is still acknowledged.
      for (int off = 0; off <= 8'h14; off += 4) begin
         rd(8'(off), d, t);
         check($sformatf("reset_read_%02h", off), d, 0);
      end

      // Byte strobes, width truncation and out-of-window access.
      bus_xfer(BASE + 32'h08, 4'b0101, 32'hAABB_CCDD, d, t);
      rd(8'h08, d, t);
      check("reload_strobes", d, 32'h00BB_00DD);
      wr(8'h04, 32'hFFFF_FFFF, t);
      rd(8'h04, d, t);
      check("prescale_width", d, 32'h0000_FFFF);
      wr(8'h00, 32'hFFFF_FFF6, t);
      rd(8'h00, d, t);
      check("ctrl_width", d, 32'h0000_0006);
      wr(8'h18, 32'hFFFF_FFFF, t);
      rd(8'h18, d, t);
      check("unmapped_read", d, 0);
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = 32'h0400_0008;
      bus.iomem_wstrb = 4'b1111;
      bus.iomem_wdata = 32'h1234_5678;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("miss_ready", bus.iomem_ready, 0);
         check("miss_rdata", bus.iomem_rdata, 0);
      end
      @(negedge clk);
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      rd(8'h08, d, t);
      check("miss_no_write", d, 32'h00BB_00DD);

      // Periodic: period (3+1)*(1+1) = 8, irq follows EXPIRED, clear drops irq.
      start_timer(1, 3, 3, 1'b1, 1'b1);
      poll_irq(20, "periodic_irq");
      wr(8'h10, 32'd1, t);
      m_clr = t;
      poll_irq(20, "periodic_irq_after_clear");
      rd(8'h10, d, t);
      check("periodic_status", d, {31'd0, expired_after(t - 1)});
      rd(8'h0C, d, t);
      check("periodic_count", d, 32'(count_after(t - 1)));

      // One-shot: COUNT=2, PRESCALE=0, CTRL=1.
      start_timer(0, 2, 0, 1'b0, 1'b0);
      rd(8'h10, d, t);
      check("oneshot_status_early", d, {31'd0, expired_after(t - 1)});
      rd(8'h10, d, t);
      check("oneshot_status_late", d, {31'd0, expired_after(t - 1)});
      rd(8'h00, d, t);
      check("oneshot_ctrl", d, 32'(ctrl_after(t - 1)));
      rd(8'h0C, d, t);
      check("oneshot_count", d, 32'(count_after(t - 1)));
      poll_irq(4, "oneshot_irq_masked");

      // Collision: clear on the expiry edge loses to the new expiry.
      start_timer(0, 4, 0, 1'b0, 1'b0);
      wait_commit_at(m_e + 5);
      wr(8'h10, 32'd1, t);
      m_clr = t;
      rd(8'h10, d, t);
      check("clear_vs_expiry", d, {31'd0, expired_after(t - 1)});
      wr(8'h10, 32'd1, t);
      m_clr = t;
      rd(8'h10, d, t);
      check("clear_later", d, {31'd0, expired_after(t - 1)});

      // Collision: COUNT write on a tick edge keeps the bus value.
      start_timer(3, 50, 50, 1'b1, 1'b0);
      wait_commit_at(m_e + 8);
      wr(8'h0C, 32'd100, t);
      rd(8'h0C, d, t);
      check("count_write_on_tick", d, 32'd100);

      // Reset on the commit edge abandons the transfer.
      reset_dut();
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE + 32'h0C;
      bus.iomem_wstrb = 4'b1111;
      bus.iomem_wdata = 32'h0000_0055;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid_ready", bus.iomem_ready, 0);
      check("reset_mid_rdata", bus.iomem_rdata, 0);
      @(negedge clk);
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      reset = 1'b0;
      @(posedge clk);
      #1;
      rd(8'h0C, d, t);
      check("reset_mid_count", d, 0);

      // Random configurations against the model.
      for (int trial = 0; trial < 8; trial++) begin
         start_timer(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'b1);
         poll_irq(int'($urandom_range(0, 40)), $sformatf("rand%0d_irq", trial));
         rd(8'h0C, d, t);
         check($sformatf("rand%0d_count", trial), d, 32'(count_after(t - 1)));
         rd(8'h10, d, t);
         check($sformatf("rand%0d_status", trial), d, {31'd0, expired_after(t - 1)});
         rd(8'h00, d, t);
         check($sformatf("rand%0d_ctrl", trial), d, 32'(ctrl_after(t - 1)));
         wr(8'h10, 32'd1, t);
         m_clr = t;
         poll_irq(6, $sformatf("rand%0d_irq_clr", trial));
         rd(8'h10, d, t);
         check($sformatf("rand%0d_status_clr", trial), d, {31'd0, expired_after(t - 1)});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
